// File: rtl/fir_pkg.sv
// Shared types and helpers for the time-multiplexed FIR filter.
// Holds the FSM encoding, width derivations and the output saturation function.
package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  // Working width for the saturation helper; accumulators are sign-extended into it.
  localparam int unsigned SAT_W = 64;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Full-precision accumulator width: product growth plus one bit per tap doubling.
  function automatic int unsigned acc_w(input int unsigned data_w,
                                        input int unsigned coef_w,
                                        input int unsigned taps);
    return data_w + coef_w + clog2(taps);
  endfunction

  function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] v,
                                                       input int unsigned out_w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Coefficient register file for the serial FIR: reset to pass-through (coef[0]=1),
// writable only while the filter is idle and the address is a real tap.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int unsigned COEF_W = 8,
  parameter int unsigned TAPS   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  state_e                     state,
  input  logic                       wr,
  input  logic [clog2(TAPS)-1:0]     wr_addr,
  input  logic [COEF_W-1:0]          wr_dat,
  input  logic [clog2(TAPS)-1:0]     rd_idx,
  output logic signed [COEF_W-1:0]   rd_dat_c
);

  logic signed [COEF_W-1:0] coef_q [TAPS];
  logic signed [COEF_W-1:0] coef_d [TAPS];
  logic                     wr_ok_c;

  always_comb begin
    wr_ok_c = wr && (state == ST_IDLE) && (32'(wr_addr) < TAPS);
    coef_d  = coef_q;
    if (wr_ok_c) coef_d[wr_addr] = wr_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(TAPS); i++) coef_q[i] <= (i == 0) ? COEF_W'(1) : '0;
    end else begin
      coef_q <= coef_d;
    end
  end

  assign rd_dat_c = coef_q[rd_idx];

endmodule

// File: rtl/fir_serial_mac.sv
// Time-multiplexed FIR: one shared multiplier, TAPS MAC cycles per sample,
// valid/ready on both sides, output arithmetic shift followed by saturation.
module fir_serial_mac
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COEF_W = 8,
  parameter int unsigned TAPS   = 8,
  parameter int unsigned OUT_W  = 16,
  parameter int unsigned SHIFT  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       x_dat,
  input  logic                    x_vld,
  output logic                    x_rdy,
  output logic [OUT_W-1:0]        y_dat,
  output logic                    y_vld,
  input  logic                    y_rdy,
  input  logic                    coef_wr,
  input  logic [clog2(TAPS)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]       coef_dat,
  output logic                    busy
);

  localparam int unsigned IDX_W  = clog2(TAPS);
  localparam int unsigned ACC_W  = acc_w(DATA_W, COEF_W, TAPS);
  localparam int unsigned PROD_W = DATA_W + COEF_W;

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [DATA_W-1:0] dly_q [TAPS];
  logic signed [DATA_W-1:0] dly_d [TAPS];
  logic [OUT_W-1:0]         y_dat_q, y_dat_d;
  logic                     y_vld_q, y_vld_d;
  logic                     x_rdy_q, x_rdy_d;
  logic                     busy_q, busy_d;

  logic signed [COEF_W-1:0] coef_rd_c;
  logic signed [DATA_W-1:0] dly_rd_c;
  logic signed [PROD_W-1:0] prod_c;
  logic signed [ACC_W-1:0]  sum_c;
  logic signed [ACC_W-1:0]  shr_c;

  fir_coef_bank #(
    .COEF_W (COEF_W),
    .TAPS   (TAPS)
  ) u_coef_bank (
    .clk      (clk),
    .rst      (rst),
    .state    (state_q),
    .wr       (coef_wr),
    .wr_addr  (coef_addr),
    .wr_dat   (coef_dat),
    .rd_idx   (idx_q),
    .rd_dat_c (coef_rd_c)
  );

  // Shared MAC datapath; the sum already includes the current tap's product.
  always_comb begin
    dly_rd_c = dly_q[idx_q];
    prod_c   = PROD_W'(dly_rd_c) * PROD_W'(coef_rd_c);
    sum_c    = acc_q + ACC_W'(prod_c);
    shr_c    = sum_c >>> SHIFT;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    dly_d   = dly_q;
    y_dat_d = y_dat_q;
    y_vld_d = y_vld_q;
    unique case (state_q)
      ST_IDLE: begin
        if (x_vld && x_rdy_q) begin
          dly_d[0] = x_dat;
          for (int i = 1; i < int'(TAPS); i++) dly_d[i] = dly_q[i-1];
          acc_d   = '0;
          idx_d   = '0;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        acc_d = sum_c;
        if (idx_q == IDX_W'(TAPS - 1)) begin
          idx_d   = '0;
          y_dat_d = OUT_W'(saturate(SAT_W'(shr_c), OUT_W));
          y_vld_d = 1'b1;
          state_d = ST_OUT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_OUT: begin
        if (y_rdy) begin
          y_vld_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    x_rdy_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      for (int i = 0; i < int'(TAPS); i++) dly_q[i] <= '0;
      y_dat_q <= '0;
      y_vld_q <= 1'b0;
      x_rdy_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      dly_q   <= dly_d;
      y_dat_q <= y_dat_d;
      y_vld_q <= y_vld_d;
      x_rdy_q <= x_rdy_d;
      busy_q  <= busy_d;
    end
  end

  assign x_rdy = x_rdy_q;
  assign y_dat = y_dat_q;
  assign y_vld = y_vld_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_fir_serial_mac.sv
// Randomised bench for fir_serial_mac: a default 8-tap instance and a 6-tap,
// SHIFT=3 instance, both compared against a convolution-sum reference model.
module tb_fir_serial_mac;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [7:0]  x_dat, a_x_dat;
  logic        x_vld, a_x_vld;
  logic        x_rdy, a_x_rdy;
  logic [15:0] y_dat, a_y_dat;
  logic        y_vld, a_y_vld;
  logic        y_rdy, a_y_rdy;
  logic        coef_wr, a_coef_wr;
  logic [2:0]  coef_addr, a_coef_addr;
  logic [7:0]  coef_dat, a_coef_dat;
  logic        busy, a_busy;

  int n_checks = 0;
  int n_errors = 0;

  longint coef_m [2][8];
  longint hist_m [2][8];
  int     taps_m [2] = '{8, 6};
  int     shift_m[2] = '{0, 3};

  fir_serial_mac #(.DATA_W(8), .COEF_W(8), .TAPS(8), .OUT_W(16), .SHIFT(0)) u_main (
    .clk(clk), .rst(rst), .x_dat(x_dat), .x_vld(x_vld), .x_rdy(x_rdy),
    .y_dat(y_dat), .y_vld(y_vld), .y_rdy(y_rdy), .coef_wr(coef_wr),
    .coef_addr(coef_addr), .coef_dat(coef_dat), .busy(busy)
  );

  fir_serial_mac #(.DATA_W(8), .COEF_W(8), .TAPS(6), .OUT_W(16), .SHIFT(3)) u_alt (
    .clk(clk), .rst(rst), .x_dat(a_x_dat), .x_vld(a_x_vld), .x_rdy(a_x_rdy),
    .y_dat(a_y_dat), .y_vld(a_y_vld), .y_rdy(a_y_rdy), .coef_wr(a_coef_wr),
    .coef_addr(a_coef_addr), .coef_dat(a_coef_dat), .busy(a_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: y = sat(floor(sum coef[i]*x[n-i] / 2^SHIFT)) on 16-bit output.
  function automatic void model_reset();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 8; i++) begin
        coef_m[s][i] = (i == 0) ? 1 : 0;
        hist_m[s][i] = 0;
      end
  endfunction

  function automatic void model_push(input int s, input longint x);
    for (int i = 7; i > 0; i--) hist_m[s][i] = hist_m[s][i-1];
    hist_m[s][0] = x;
  endfunction

  function automatic longint model_y(input int s);
    longint acc = 0;
    for (int i = 0; i < taps_m[s]; i++) acc += coef_m[s][i] * hist_m[s][i];
    acc = acc >>> shift_m[s];
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return acc;
  endfunction

  function automatic longint o_ydat(input int s);
    return (s == 0) ? longint'($signed(y_dat)) : longint'($signed(a_y_dat));
  endfunction
  function automatic longint o_yvld(input int s);
    return (s == 0) ? longint'(y_vld) : longint'(a_y_vld);
  endfunction
  function automatic longint o_xrdy(input int s);
    return (s == 0) ? longint'(x_rdy) : longint'(a_x_rdy);
  endfunction
  function automatic longint o_busy(input int s);
    return (s == 0) ? longint'(busy) : longint'(a_busy);
  endfunction

  task automatic drv_x(input int s, input logic v, input int x);
    if (s == 0) begin x_vld = v; x_dat = 8'(x); end
    else        begin a_x_vld = v; a_x_dat = 8'(x); end
  endtask

  task automatic drv_wr(input int s, input logic v, input int addr, input int val);
    if (s == 0) begin coef_wr = v; coef_addr = 3'(addr); coef_dat = 8'(val); end
    else        begin a_coef_wr = v; a_coef_addr = 3'(addr); a_coef_dat = 8'(val); end
  endtask

  task automatic drv_yrdy(input int s, input logic v);
    if (s == 0) y_rdy = v; else a_y_rdy = v;
  endtask

  function automatic int rnd_s8();
    return int'($urandom_range(255)) - 128;
  endfunction

  // Idle-time coefficient write; the model applies it only for a real tap.
  task automatic write_coef(input int s, input int addr, input int val);
    @(negedge clk);
    drv_wr(s, 1'b1, addr, val);
    @(posedge clk);
    #1;
    drv_wr(s, 1'b0, 0, 0);
    if (addr < taps_m[s]) coef_m[s][addr] = longint'(val);
  endtask

  // One full sample transaction with optional same-edge write, MAC-time write and output stall.
  task automatic send(input int s, input int x, input bit wr, input int waddr, input int wval,
                      input int stall, input bit macwr, output longint y);
    int n;
    longint exp;
    @(negedge clk);
    chk("x_rdy_idle", o_xrdy(s), 1);
    drv_yrdy(s, stall == 0);
    drv_x(s, 1'b1, x);
    if (wr) begin
      drv_wr(s, 1'b1, waddr, wval);
      if (waddr < taps_m[s]) coef_m[s][waddr] = longint'(wval);
    end
    @(posedge clk);
    #1;
    drv_x(s, 1'b0, 0);
    drv_wr(s, 1'b0, 0, 0);
    model_push(s, longint'(x));
    exp = model_y(s);
    chk("x_rdy_mac", o_xrdy(s), 0);
    chk("busy_mac", o_busy(s), 1);
    n = 0;
    while (n < 20) begin
      if (macwr && n == 2) drv_wr(s, 1'b1, 0, 50);
      @(posedge clk);
      #1;
      n++;
      drv_wr(s, 1'b0, 0, 0);
      if (o_yvld(s) == 1) break;
    end
    chk("latency", longint'(n), longint'(taps_m[s]));
    y = o_ydat(s);
    chk("y_dat", y, exp);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      drv_x(s, 1'b1, rnd_s8());
      @(posedge clk);
      #1;
      drv_x(s, 1'b0, 0);
      chk("bp_y_vld", o_yvld(s), 1);
      chk("bp_y_dat", o_ydat(s), exp);
      chk("bp_x_rdy", o_xrdy(s), 0);
      chk("bp_busy", o_busy(s), 1);
    end
    @(negedge clk);
    drv_yrdy(s, 1'b1);
    @(posedge clk);
    #1;
    chk("ret_y_vld", o_yvld(s), 0);
    chk("ret_x_rdy", o_xrdy(s), 1);
    chk("hold_y_dat", o_ydat(s), exp);
  endtask

  initial begin
    longint y;
    int     pass_v[3] = '{5, -3, 100};
    x_vld = 1'b0; x_dat = '0; y_rdy = 1'b1; coef_wr = 1'b0; coef_addr = '0; coef_dat = '0;
    a_x_vld = 1'b0; a_x_dat = '0; a_y_rdy = 1'b1; a_coef_wr = 1'b0; a_coef_addr = '0; a_coef_dat = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_x_rdy", longint'(x_rdy), 1);
    chk("rst_y_vld", longint'(y_vld), 0);
    chk("rst_y_dat", longint'(y_dat), 0);
    chk("rst_busy", longint'(busy), 0);

    foreach (pass_v[i]) begin
      send(0, pass_v[i], 0, 0, 0, 0, 0, y);
      chk("pass_through", y, longint'(pass_v[i]));
    end

    // Impulse response after flushing the delay line
    for (int i = 0; i < 8; i++) send(0, 0, 0, 0, 0, 0, 0, y);
    for (int i = 0; i < 8; i++) write_coef(0, i, i + 1);
    for (int i = 0; i < 8; i++) begin
      send(0, (i == 0) ? 1 : 0, 0, 0, 0, 0, 0, y);
      chk("impulse", y, longint'(i + 1));
    end

    for (int i = 0; i < 8; i++) write_coef(0, i, 127);
    for (int i = 0; i < 8; i++) send(0, 127, 0, 0, 0, 0, 0, y);
    chk("sat_pos", y, 32767);
    for (int i = 0; i < 8; i++) send(0, -128, 0, 0, 0, 0, 0, y);
    chk("sat_neg", y, -32768);

    send(0, 33, 0, 0, 0, 5, 0, y);
    send(0, -17, 0, 0, 0, 0, 1, y);
    send(0, 21, 0, 0, 0, 0, 0, y);
    send(0, 11, 1, 0, -5, 0, 0, y);
    send(0, -60, 0, 0, 0, 0, 0, y);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(2) == 0) write_coef(0, int'($urandom_range(7)), rnd_s8());
      send(0, rnd_s8(), $urandom_range(3) == 0, int'($urandom_range(7)), rnd_s8(),
           int'($urandom_range(3)), $urandom_range(4) == 0, y);
    end

    send(1, -9, 0, 0, 0, 0, 0, y);
    chk("shift_floor", y, -2);
    write_coef(1, 6, 50);
    write_coef(1, 7, 50);
    send(1, 40, 0, 0, 0, 0, 0, y);
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(1) == 0) write_coef(1, int'($urandom_range(7)), rnd_s8());
      send(1, rnd_s8(), $urandom_range(3) == 0, int'($urandom_range(7)), rnd_s8(),
           int'($urandom_range(2)), $urandom_range(4) == 0, y);
    end

    // Reset three cycles into MAC discards the sample and restores defaults
    @(negedge clk);
    drv_x(0, 1'b1, 13);
    @(posedge clk);
    #1;
    drv_x(0, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_y_vld", longint'(y_vld), 0);
    chk("midrst_x_rdy", longint'(x_rdy), 1);
    chk("midrst_busy", longint'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    send(0, 7, 0, 0, 0, 0, 0, y);
    chk("post_rst", y, 7);
    send(0, -44, 0, 0, 0, 0, 0, y);
    send(1, 40, 0, 0, 0, 0, 0, y);
    chk("post_rst_alt", y, 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
